// File: rtl/adc_capture16_pkg.sv
// Shared constants, FSM encoding and slice helper for the 16-channel ADC capture block.
package adc_capture16_pkg;

    localparam int NUM_CH   = 16;
    localparam int ADC_BITS = 16;
    localparam int BUS_W    = NUM_CH * ADC_BITS;
    localparam int ACC_BITS = ADC_BITS + 2;
    localparam int BIT_W    = $clog2(ADC_BITS);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        SHIFT  = 2'd2,
        COMMIT = 2'd3
    } state_t;

    // Lowest bit position of channel ch inside the flattened channel bus.
    function automatic int ch_lsb(input int ch);
        return ch * ADC_BITS;
    endfunction

endpackage

// File: rtl/adc_spi_shifter.sv
// 16-lane SPI receiver: generates SCLK and shifts all SDO lines in parallel, MSB first.
// Handshake: 'start' is a one-cycle request that (re)arms a 16-bit frame; 'done' is
// high for exactly one cycle, the cycle whose closing edge drives SCLK low after the
// 16th high phase. shift_data is stable from that edge until the next start.
module adc_spi_shifter
    import adc_capture16_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic              CLK_50M,
    input  logic              RESET_n,
    input  logic              start,
    input  logic [NUM_CH-1:0] sdo,
    output logic              sclk,
    output logic              done,
    output logic [BUS_W-1:0]  shift_data
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic                active;
    logic [DIV_W-1:0]    div_cnt;
    logic [BIT_W-1:0]    bit_cnt;
    logic [ADC_BITS-1:0] lane [NUM_CH];

    // SCLK phase timing, bit counting and capture of SDO on the low-to-high transition
    always_ff @(posedge CLK_50M or negedge RESET_n) begin
        if (!RESET_n) begin
            active  <= 1'b0;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                lane[k] <= '0;
            end
        end else if (start) begin
            active  <= 1'b1;
            sclk    <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
        end else if (active) begin
            if (div_cnt == DIV_W'(CLK_DIV - 1)) begin
                div_cnt <= '0;
                if (!sclk) begin
                    sclk <= 1'b1;
                    for (int k = 0; k < NUM_CH; k++) begin
                        lane[k] <= {lane[k][ADC_BITS-2:0], sdo[k]};
                    end
                end else begin
                    sclk <= 1'b0;
                    if (bit_cnt == BIT_W'(ADC_BITS - 1)) begin
                        active <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Frame-complete strobe and flattening of the lanes onto the channel bus
    always_comb begin
        done       = active && sclk && (div_cnt == DIV_W'(CLK_DIV - 1))
                     && (bit_cnt == BIT_W'(ADC_BITS - 1));
        shift_data = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            shift_data[ch_lsb(k) +: ADC_BITS] = lane[k];
        end
    end

endmodule

// File: rtl/adc_capture16.sv
// 16-channel simultaneous-sampling ADC front end: period timer, CNV pulse, SPI read
// via adc_spi_shifter, and atomic commit of all channels to DATA_OUT.
// Optional build macro ADC_AVG4_EN: accumulate four frames per channel and commit the
// truncated mean every fourth frame.
module adc_capture16
    import adc_capture16_pkg::*;
#(
    parameter int CLK_DIV       = 2,
    parameter int CONV_CYCLES   = 110,
    parameter int SAMPLE_PERIOD = 500
) (
    input  logic              CLK_50M,
    input  logic              RESET_n,
    input  logic              EN,
    input  logic              FREEZE,
    input  logic [NUM_CH-1:0] SDO,
    output logic              CNV,
    output logic              SCLK,
    output logic [BUS_W-1:0]  DATA_OUT,
    output logic              VALID,
    output logic              OVERRUN
);

    localparam int PW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CW = $clog2(CONV_CYCLES + 1);

    state_t            state;
    logic [PW-1:0]     period_cnt;
    logic [CW-1:0]     conv_cnt;
    logic              tick;
    logic              shift_start;
    logic              shift_done;
    logic              valid_pend;
    logic [BUS_W-1:0]  shift_data;

`ifdef ADC_AVG4_EN
    logic [ACC_BITS-1:0] acc     [NUM_CH];
    logic [ACC_BITS-1:0] acc_sum [NUM_CH];
    logic [1:0]          frame_cnt;

    // Running per-channel sum including the frame just shifted in
    always_comb begin
        for (int k = 0; k < NUM_CH; k++) begin
            acc_sum[k] = acc[k] + ACC_BITS'(shift_data[ch_lsb(k) +: ADC_BITS]);
        end
    end
`endif

    // Sample-period timer: free-runs while enabled, parked at zero otherwise
    always_ff @(posedge CLK_50M or negedge RESET_n) begin
        if (!RESET_n) begin
            period_cnt <= '0;
        end else if (!EN) begin
            period_cnt <= '0;
        end else if (period_cnt == PW'(SAMPLE_PERIOD - 1)) begin
            period_cnt <= '0;
        end else begin
            period_cnt <= period_cnt + 1'b1;
        end
    end

    // Tick and the shifter kick-off on the last CNV-high cycle
    always_comb begin
        tick        = EN && (period_cnt == '0);
        shift_start = (state == CONV) && (conv_cnt == CW'(CONV_CYCLES - 1));
    end

    adc_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .CLK_50M    (CLK_50M),
        .RESET_n    (RESET_n),
        .start      (shift_start),
        .sdo        (SDO),
        .sclk       (SCLK),
        .done       (shift_done),
        .shift_data (shift_data)
    );

    // Frame sequencer: conversion pulse, wait for the read, commit, flags
    always_ff @(posedge CLK_50M or negedge RESET_n) begin
        if (!RESET_n) begin
            state      <= IDLE;
            CNV        <= 1'b0;
            conv_cnt   <= '0;
            DATA_OUT   <= '0;
            valid_pend <= 1'b0;
            VALID      <= 1'b0;
            OVERRUN    <= 1'b0;
`ifdef ADC_AVG4_EN
            frame_cnt  <= '0;
            for (int k = 0; k < NUM_CH; k++) begin
                acc[k] <= '0;
            end
`endif
        end else begin
            valid_pend <= 1'b0;
            VALID      <= valid_pend;
            if (tick && (state != IDLE)) begin
                OVERRUN <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        CNV      <= 1'b1;
                        conv_cnt <= '0;
                        state    <= CONV;
                    end
                end
                CONV: begin
                    if (conv_cnt == CW'(CONV_CYCLES - 1)) begin
                        CNV   <= 1'b0;
                        state <= SHIFT;
                    end else begin
                        conv_cnt <= conv_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (shift_done) begin
                        state <= COMMIT;
                    end
                end
                COMMIT: begin
`ifdef ADC_AVG4_EN
                    if (frame_cnt == 2'd3) begin
                        if (!FREEZE) begin
                            for (int k = 0; k < NUM_CH; k++) begin
                                DATA_OUT[ch_lsb(k) +: ADC_BITS] <= acc_sum[k][ACC_BITS-1:2];
                            end
                            valid_pend <= 1'b1;
                        end
                        for (int k = 0; k < NUM_CH; k++) begin
                            acc[k] <= '0;
                        end
                        frame_cnt <= '0;
                    end else begin
                        for (int k = 0; k < NUM_CH; k++) begin
                            acc[k] <= acc_sum[k];
                        end
                        frame_cnt <= frame_cnt + 1'b1;
                    end
`else
                    if (!FREEZE) begin
                        DATA_OUT   <= shift_data;
                        valid_pend <= 1'b1;
                    end
`endif
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_capture16.sv
// Self-checking bench for adc_capture16: behavioural ADC array on SDO, scoreboard of
// expected DATA_OUT words, timing checks on CNV/SCLK/VALID, FREEZE, overrun and reset.
// Honours ADC_AVG4_EN in its reference model.
module tb_adc_capture16;
    import adc_capture16_pkg::*;

    localparam int CLK_DIV       = 2;
    localparam int CONV_CYCLES   = 110;
    localparam int SAMPLE_PERIOD = 500;
    localparam int LAT           = CONV_CYCLES + 32 * CLK_DIV + 1;

    // ---------------- clock / reset ----------------
    logic CLK_50M = 1'b0;
    logic RESET_n = 1'b0;
    logic EN      = 1'b0;
    logic FREEZE  = 1'b0;
    logic [NUM_CH-1:0] SDO = '0;

    always #10 CLK_50M = ~CLK_50M;

    logic             CNV, SCLK, VALID, OVERRUN;
    logic [BUS_W-1:0] DATA_OUT;
    logic             ovr_cnv, ovr_sclk, ovr_valid, ovr_overrun;
    logic [BUS_W-1:0] ovr_data;

    adc_capture16 #(
        .CLK_DIV       (CLK_DIV),
        .CONV_CYCLES   (CONV_CYCLES),
        .SAMPLE_PERIOD (SAMPLE_PERIOD)
    ) dut (
        .CLK_50M  (CLK_50M),
        .RESET_n  (RESET_n),
        .EN       (EN),
        .FREEZE   (FREEZE),
        .SDO      (SDO),
        .CNV      (CNV),
        .SCLK     (SCLK),
        .DATA_OUT (DATA_OUT),
        .VALID    (VALID),
        .OVERRUN  (OVERRUN)
    );

    // Second instance with a sample period too short for one frame
    adc_capture16 #(
        .CLK_DIV       (CLK_DIV),
        .CONV_CYCLES   (CONV_CYCLES),
        .SAMPLE_PERIOD (100)
    ) dut_ovr (
        .CLK_50M  (CLK_50M),
        .RESET_n  (RESET_n),
        .EN       (EN),
        .FREEZE   (FREEZE),
        .SDO      (SDO),
        .CNV      (ovr_cnv),
        .SCLK     (ovr_sclk),
        .DATA_OUT (ovr_data),
        .VALID    (ovr_valid),
        .OVERRUN  (ovr_overrun)
    );

    // ---------------- ADC array model ----------------
    // MSB appears once CNV falls; each SCLK falling edge presents the next bit.
    logic [ADC_BITS-1:0] adc_word [NUM_CH];
    int   bit_idx    = 0;
    logic cnv_q      = 1'b0;
    logic sclk_q     = 1'b0;
    int   sclk_rises = 0;

    always @(negedge CLK_50M) begin
        if (cnv_q && !CNV) begin
            bit_idx = ADC_BITS - 1;
        end else if (sclk_q && !SCLK && bit_idx > 0) begin
            bit_idx = bit_idx - 1;
        end
        if (!sclk_q && SCLK) begin
            sclk_rises = sclk_rises + 1;
        end
        cnv_q  = CNV;
        sclk_q = SCLK;
        for (int k = 0; k < NUM_CH; k++) begin
            SDO[k] = adc_word[k][bit_idx];
        end
    end

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_pass   = 0;
    logic [BUS_W-1:0] exp_q [$];
    logic [BUS_W-1:0] last_data = '0;
`ifdef ADC_AVG4_EN
    logic [ACC_BITS-1:0] m_acc [NUM_CH];
    int m_cnt = 0;
`endif

    task automatic check_eq(input string tag, input logic [BUS_W-1:0] got,
                            input logic [BUS_W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        last_data = '0;
`ifdef ADC_AVG4_EN
        for (int k = 0; k < NUM_CH; k++) m_acc[k] = '0;
        m_cnt = 0;
`endif
    endtask

    // Drive one frame of ADC data, predict the result, then watch the DUT through it.
    task automatic run_frame(input logic [BUS_W-1:0] words, input logic frz);
        logic [BUS_W-1:0] prev_data;
        logic [BUS_W-1:0] new_data;
        int pushed    = 0;
        int wait_cyc  = 0;
        int valid_cnt = 0;
        int valid_at  = -1;
        int rises0;

        for (int k = 0; k < NUM_CH; k++) adc_word[k] = words[k*ADC_BITS +: ADC_BITS];
        FREEZE    = frz;
        prev_data = last_data;
        new_data  = last_data;
`ifdef ADC_AVG4_EN
        for (int k = 0; k < NUM_CH; k++) m_acc[k] = m_acc[k] + ACC_BITS'(words[k*ADC_BITS +: ADC_BITS]);
        if (m_cnt == 3) begin
            for (int k = 0; k < NUM_CH; k++) new_data[k*ADC_BITS +: ADC_BITS] = m_acc[k][ACC_BITS-1:2];
            if (!frz) pushed = 1;
            for (int k = 0; k < NUM_CH; k++) m_acc[k] = '0;
            m_cnt = 0;
        end else begin
            m_cnt++;
        end
`else
        new_data = words;
        if (!frz) pushed = 1;
`endif
        if (pushed == 1) begin
            exp_q.push_back(new_data);
            last_data = new_data;
        end

        do begin
            @(negedge CLK_50M);
            wait_cyc++;
        end while (CNV !== 1'b1 && wait_cyc < 2 * SAMPLE_PERIOD);
        check_eq("tick_seen", BUS_W'(CNV), BUS_W'(1));
        if (CNV !== 1'b1) return;

        rises0 = sclk_rises;
        for (int i = 1; i <= LAT + 15; i++) begin
            @(negedge CLK_50M);
            if (i == CONV_CYCLES - 1) check_eq("cnv_high", BUS_W'(CNV), BUS_W'(1));
            if (i == CONV_CYCLES)     check_eq("cnv_low", BUS_W'(CNV), BUS_W'(0));
            if (pushed == 1 && i == LAT - 1) check_eq("data_pre_lat", DATA_OUT, prev_data);
            if (pushed == 1 && i == LAT)     check_eq("data_at_lat", DATA_OUT, new_data);
            if (VALID) begin
                valid_cnt++;
                if (valid_at < 0) valid_at = i;
                if (exp_q.size() > 0) check_eq("data", DATA_OUT, exp_q.pop_front());
                else check_eq("valid_unexpected", BUS_W'(VALID), BUS_W'(0));
            end
        end
        check_eq("valid_count", BUS_W'(valid_cnt), BUS_W'(pushed));
        if (pushed == 1) check_eq("valid_latency", BUS_W'(valid_at), BUS_W'(LAT + 1));
        check_eq("sclk_rises", BUS_W'(sclk_rises - rises0), BUS_W'(ADC_BITS));
        check_eq("data_hold", DATA_OUT, last_data);
        check_eq("no_overrun", BUS_W'(OVERRUN), BUS_W'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [BUS_W-1:0] w;
        logic [ADC_BITS-1:0] ch3_exp;
        int cnt;
        int cnv_cnt;

        for (int k = 0; k < NUM_CH; k++) adc_word[k] = '0;
        model_reset();

        // Reset held with EN=1: everything quiet
        EN      = 1'b1;
        RESET_n = 1'b0;
        repeat (5) @(negedge CLK_50M);
        check_eq("rst_cnv", BUS_W'(CNV), BUS_W'(0));
        check_eq("rst_sclk", BUS_W'(SCLK), BUS_W'(0));
        check_eq("rst_data", DATA_OUT, '0);
        check_eq("rst_valid", BUS_W'(VALID), BUS_W'(0));
        check_eq("rst_overrun", BUS_W'(OVERRUN), BUS_W'(0));
        check_eq("rst_ovr_overrun", BUS_W'(ovr_overrun), BUS_W'(0));
        RESET_n = 1'b1;

        // Basic capture: channel k = 0x1000 + k
        for (int k = 0; k < NUM_CH; k++) w[k*ADC_BITS +: ADC_BITS] = 16'h1000 + 16'(k);
        run_frame(w, 1'b0);

        // Bit order and extremes
        for (int k = 0; k < NUM_CH; k++) w[k*ADC_BITS +: ADC_BITS] = 16'($urandom_range(0, 65535));
        w[0*ADC_BITS +: ADC_BITS]  = 16'h8001;
        w[7*ADC_BITS +: ADC_BITS]  = 16'h0000;
        w[15*ADC_BITS +: ADC_BITS] = 16'hFFFF;
        run_frame(w, 1'b0);

        // FREEZE: commit AAAA, hold through a frozen 5555 frame, then take 5555
        run_frame({NUM_CH{16'hAAAA}}, 1'b0);
        run_frame({NUM_CH{16'h5555}}, 1'b1);
`ifndef ADC_AVG4_EN
        check_eq("freeze_hold", DATA_OUT, {NUM_CH{16'hAAAA}});
`endif
        run_frame({NUM_CH{16'h5555}}, 1'b0);

        // Random frames
        for (int f = 0; f < 2; f++) begin
            for (int k = 0; k < NUM_CH; k++) w[k*ADC_BITS +: ADC_BITS] = 16'($urandom_range(0, 65535));
            run_frame(w, 1'b0);
        end

        // Too-short sample period must have flagged overrun
        check_eq("ovr_overrun", BUS_W'(ovr_overrun), BUS_W'(1));

        // Reset in the middle of SHIFT, while SCLK is high
        cnt = 0;
        do begin
            @(negedge CLK_50M);
            cnt++;
        end while (CNV !== 1'b1 && cnt < 2 * SAMPLE_PERIOD);
        check_eq("mid_tick_seen", BUS_W'(CNV), BUS_W'(1));
        repeat (CONV_CYCLES + CLK_DIV) @(negedge CLK_50M);
        check_eq("mid_sclk_high", BUS_W'(SCLK), BUS_W'(1));
        #3;
        RESET_n = 1'b0;
        #1;
        check_eq("mid_rst_cnv", BUS_W'(CNV), BUS_W'(0));
        check_eq("mid_rst_sclk", BUS_W'(SCLK), BUS_W'(0));
        check_eq("mid_rst_data", DATA_OUT, '0);
        check_eq("mid_rst_overrun", BUS_W'(ovr_overrun), BUS_W'(0));
        model_reset();
        EN = 1'b0;
        @(negedge CLK_50M);
        RESET_n = 1'b1;
        cnt     = 0;
        cnv_cnt = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge CLK_50M);
            if (VALID) cnt++;
            if (CNV) cnv_cnt++;
        end
        check_eq("post_rst_no_valid", BUS_W'(cnt), BUS_W'(0));
        check_eq("en_low_no_cnv", BUS_W'(cnv_cnt), BUS_W'(0));
        check_eq("post_rst_data", DATA_OUT, '0);

        // Four frames on channel 3: 100, 101, 102, 104
        EN = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < NUM_CH; k++) w[k*ADC_BITS +: ADC_BITS] = 16'(k * 16'h0111 + f);
            case (f)
                0: w[3*ADC_BITS +: ADC_BITS] = 16'd100;
                1: w[3*ADC_BITS +: ADC_BITS] = 16'd101;
                2: w[3*ADC_BITS +: ADC_BITS] = 16'd102;
                default: w[3*ADC_BITS +: ADC_BITS] = 16'd104;
            endcase
            run_frame(w, 1'b0);
        end
`ifdef ADC_AVG4_EN
        ch3_exp = 16'd101;
`else
        ch3_exp = 16'd104;
`endif
        check_eq("ch3_final", BUS_W'(DATA_OUT[3*ADC_BITS +: ADC_BITS]), BUS_W'(ch3_exp));
        check_eq("queue_empty", BUS_W'(exp_q.size()), BUS_W'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/adc_capture16.md
Name: adc_capture16

Overview:
- Upstream stage of the 16-channel UART data transmitter.
- Drives 16 parallel 16-bit SPI ADCs (AD7685-class, CNV-start, MSB-first SDO) from one shared CNV/SCLK pair and shifts in all 16 SDO lines simultaneously.
- Presents 16 coherent 16-bit channel words that the transmitter snapshots on host request.
- Results update atomically: all channels change in the same clock cycle.

Parameters:
- CLK_DIV, 2, SCLK half-period in clock cycles (2 gives 12.5 MHz at 50 MHz); legal range 1 or more.
- CONV_CYCLES, 110, CNV high time in clock cycles (2.2 us conversion).
- SAMPLE_PERIOD, 500, clock cycles between conversion starts (100 kS/s). Must be at least CONV_CYCLES + 32*CLK_DIV + 2.

Ports:
- CLK_50M  input  1  system clock, 50 MHz
- RESET_n  input  1  asynchronous active-low reset
- EN  input  1  enables periodic conversions
- FREEZE  input  1  while high, new results are not committed to DATA_OUT
- SDO  input  16  serial data from ADCs; bit k comes from channel k
- CNV  output  1  conversion start, shared by all ADCs
- SCLK  output  1  serial clock, shared; idles low
- DATA_OUT  output  256  channel k occupies bits [16k+15:16k]
- VALID  output  1  one-cycle pulse in the cycle after DATA_OUT updates
- OVERRUN  output  1  sticky flag; cleared only by reset

Behaviour:
- Reset: async assert of RESET_n clears all registers. CNV=0, SCLK=0, DATA_OUT=0, VALID=0, OVERRUN=0, state=IDLE, period counter=0. Reset mid-frame aborts the frame; no partial data is committed.
- Period counter:
  - Counts 0..SAMPLE_PERIOD-1 while EN=1 and wraps to 0.
  - It is held at 0 while EN=0.
  - A tick occurs when the count is 0 and EN=1.
- States:
  - IDLE: on tick, set CNV=1, clear the bit counter, go to CONV.
  - CONV: hold CNV=1 for CONV_CYCLES cycles. Then set CNV=0 and go to SHIFT.
  - SHIFT: repeat 16 bits, MSB first:
    - SCLK low for CLK_DIV cycles.
    - On the cycle SCLK is driven high, capture raw SDO[k] into the LSB of shift register k, shifting left.
    - SCLK high for CLK_DIV cycles, then driven low.
    - After the 16th high phase, SCLK returns low and the state goes to COMMIT.
  - COMMIT (1 cycle):
    - If FREEZE=0, load all 16 shift registers into DATA_OUT and assert VALID on the next cycle.
    - If FREEZE=1, discard the frame, keep DATA_OUT unchanged, and leave VALID low.
    - Go to IDLE.
- Latency: from tick to DATA_OUT update is CONV_CYCLES + 32*CLK_DIV + 1 cycles.
- A tick arriving in any state other than IDLE sets OVERRUN=1 and is ignored. This is possible only if SAMPLE_PERIOD is illegal.
- EN deasserted mid-frame: the current frame completes normally, and no further ticks occur.
- FREEZE is sampled only in COMMIT. It has no effect on CNV or SCLK timing.
- Data is passed straight through (straight binary); no sign handling.

Optional Feature:
- Macro ADC_AVG4_EN.
- When defined:
  - Each channel keeps an 18-bit unsigned accumulator plus a shared 2-bit frame counter.
  - COMMIT adds the shifted word to the accumulator.
  - On every 4th frame, DATA_OUT is loaded with accumulator[17:2] (truncated mean), subject to FREEZE, and VALID pulses.
  - Accumulators clear after each 4th frame regardless of FREEZE.
  - Output rate becomes SAMPLE_PERIOD*4.
- When undefined: every frame commits directly, and no accumulator logic exists.

Decomposition:
- Shared package holds:
  - NUM_CH=16
  - ADC_BITS=16
  - state encoding (IDLE, CONV, SHIFT, COMMIT)
  - the channel-slice index helper constant
- One sub-module, adc_spi_shifter: a 16-lane shift register plus SCLK/bit-counter generator. It takes start and done handshakes.
- The top level holds the period counter, CNV timing, commit/average logic and flags.

Test Plan:
- Reset and idle: hold RESET_n=0 with EN=1, then release. CNV and SCLK stay 0 until the first tick. DATA_OUT=0, VALID=0, OVERRUN=0.
- Basic capture: ADC models return channel k = 16'h1000+k. After 110+64+1 cycles, DATA_OUT slice k = 16'h1000+k, VALID pulses exactly once, SCLK shows exactly 16 rising edges.
- Bit order and extremes: channel 0 = 16'h8001, channel 15 = 16'hFFFF, channel 7 = 16'h0000. Slices match exactly (MSB-first check).
- FREEZE: commit 16'hAAAA on all channels. Raise FREEZE, and the ADCs return 16'h5555. DATA_OUT stays 16'hAAAA with no VALID. Drop FREEZE; the next frame gives 16'h5555.
- Overrun and reset: set SAMPLE_PERIOD=100 with CLK_DIV=2 and CONV_CYCLES=110, and OVERRUN=1 after the second tick. Separately, assert RESET_n mid-SHIFT: CNV and SCLK go to 0 immediately, DATA_OUT=0, and no VALID appears.
- With ADC_AVG4_EN defined: channel 3 returns 100, 101, 102, 104 over four frames. DATA_OUT slice 3 = 101, VALID pulses once per 4 frames.
